// File: rtl/pipeline_exec_ctrl.sv
// Execution controller for the MIPS pipeline: sequences clear, run and
// stepped execution from debug-unit commands, stops on HALT and counts
// executed (enabled) cycles with saturation.
module pipeline_exec_ctrl #(
    parameter int unsigned CMD_SIZE     = 3,
    parameter int unsigned STEP_SIZE    = 8,
    parameter int unsigned COUNTER_SIZE = 32,
    parameter int unsigned CLEAR_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_cmd_valid,
    input  logic [CMD_SIZE-1:0]     i_cmd,
    input  logic [STEP_SIZE-1:0]    i_step_n,
    input  logic                    i_halt,
    output logic                    o_cmd_ready,
    output logic                    o_enable,
    output logic                    o_clear,
    output logic                    o_done,
    output logic                    o_halted,
    output logic [2:0]              o_state,
    output logic [COUNTER_SIZE-1:0] o_cycle_count
);

    localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    localparam logic [CMD_SIZE-1:0] CMD_RUN   = CMD_SIZE'(1);
    localparam logic [CMD_SIZE-1:0] CMD_STEP  = CMD_SIZE'(2);
    localparam logic [CMD_SIZE-1:0] CMD_STOP  = CMD_SIZE'(3);
    localparam logic [CMD_SIZE-1:0] CMD_CLEAR = CMD_SIZE'(4);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_enable;
    logic                    r_clear;
    logic                    r_done;
    logic                    r_halted;
    logic [COUNTER_SIZE-1:0] r_cycle_count;
    logic [STEP_SIZE-1:0]    r_step_left;
    logic [CLR_W-1:0]        r_clr_left;

    logic                    w_accept;
    logic                    w_cmd_run;
    logic                    w_cmd_step;
    logic                    w_cmd_stop;
    logic                    w_cmd_clear;
    logic                    w_enter_clear;
    logic                    w_count_sat;
    logic [STEP_SIZE-1:0]    w_step_load;

    // Command acceptance and decode; ready is a pure state decode
    assign o_cmd_ready = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_HALTED);
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_cmd_run   = w_accept && (i_cmd == CMD_RUN);
    assign w_cmd_step  = w_accept && (i_cmd == CMD_STEP);
    assign w_cmd_stop  = w_accept && (i_cmd == CMD_STOP);
    assign w_cmd_clear = w_accept && (i_cmd == CMD_CLEAR);

    // A clear is taken from IDLE/HALTED, and from RUN only when no halt competes
    assign w_enter_clear = w_cmd_clear &&
                           ((r_state == ST_IDLE) || (r_state == ST_HALTED) ||
                            ((r_state == ST_RUN) && !i_halt));

    assign w_step_load = (i_step_n == '0) ? STEP_SIZE'(1) : i_step_n;
    assign w_count_sat = &r_cycle_count;

    assign o_enable      = r_enable;
    assign o_clear       = r_clear;
    assign o_done        = r_done;
    assign o_halted      = r_halted;
    assign o_state       = r_state;
    assign o_cycle_count = r_cycle_count;

    // Control FSM with registered strobes and saturating cycle counter
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= ST_IDLE;
            r_enable      <= 1'b0;
            r_clear       <= 1'b0;
            r_done        <= 1'b0;
            r_halted      <= 1'b0;
            r_cycle_count <= '0;
            r_step_left   <= '0;
            r_clr_left    <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_enable && !w_count_sat) begin
                r_cycle_count <= r_cycle_count + COUNTER_SIZE'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_run) begin
                        r_state  <= ST_RUN;
                        r_enable <= 1'b1;
                    end else if (w_cmd_step) begin
                        r_state     <= ST_STEP;
                        r_enable    <= 1'b1;
                        r_step_left <= w_step_load;
                    end
                end
                ST_RUN: begin
                    if (i_halt) begin
                        r_state  <= ST_HALTED;
                        r_enable <= 1'b0;
                        r_halted <= 1'b1;
                        r_done   <= 1'b1;
                    end else if (w_cmd_stop) begin
                        r_state  <= ST_IDLE;
                        r_enable <= 1'b0;
                    end
                end
                ST_STEP: begin
                    if (i_halt) begin
                        r_state     <= ST_HALTED;
                        r_enable    <= 1'b0;
                        r_halted    <= 1'b1;
                        r_done      <= 1'b1;
                        r_step_left <= '0;
                    end else if (r_step_left <= STEP_SIZE'(1)) begin
                        r_state     <= ST_IDLE;
                        r_enable    <= 1'b0;
                        r_done      <= 1'b1;
                        r_step_left <= '0;
                    end else begin
                        r_step_left <= r_step_left - STEP_SIZE'(1);
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_left == '0) begin
                        r_state <= ST_IDLE;
                        r_clear <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_clr_left <= r_clr_left - CLR_W'(1);
                    end
                end
                ST_HALTED: begin
                    r_enable <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_enable <= 1'b0;
                    r_clear  <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase

            // Clear entry overrides the per-state updates above
            if (w_enter_clear) begin
                r_state       <= ST_CLEAR;
                r_enable      <= 1'b0;
                r_clear       <= 1'b1;
                r_halted      <= 1'b0;
                r_cycle_count <= '0;
                r_clr_left    <= CLR_W'(CLEAR_CYCLES - 1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Self-checking bench for pipeline_exec_ctrl: a cycle model of the command
// rules checked every cycle, plus directed scenarios with literal checks.
// A second instance with a 4-bit counter shares the stimulus for saturation.
module tb_pipeline_exec_ctrl;

    localparam int unsigned CLEAR_CYCLES = 2;
    localparam int C_RUN   = 1;
    localparam int C_STEP  = 2;
    localparam int C_STOP  = 3;
    localparam int C_CLEAR = 4;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [7:0]  step_n;
    logic        halt;

    logic        ready, en, clr, done, halted;
    logic [2:0]  state;
    logic [31:0] count;

    logic        ready4, en4, clr4, done4, halted4;
    logic [2:0]  state4;
    logic [3:0]  count4;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int     m_mode   = 0;
    int     m_left   = 0;
    longint m_count  = 0;
    bit     m_en     = 0;
    bit     m_clr    = 0;
    bit     m_done   = 0;
    bit     m_halted = 0;

    pipeline_exec_ctrl #(.CMD_SIZE(3), .STEP_SIZE(8), .COUNTER_SIZE(32), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_step_n(step_n), .i_halt(halt), .o_cmd_ready(ready), .o_enable(en),
        .o_clear(clr), .o_done(done), .o_halted(halted), .o_state(state),
        .o_cycle_count(count)
    );

    pipeline_exec_ctrl #(.CMD_SIZE(3), .STEP_SIZE(8), .COUNTER_SIZE(4), .CLEAR_CYCLES(CLEAR_CYCLES)) dut4 (
        .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_step_n(step_n), .i_halt(halt), .o_cmd_ready(ready4), .o_enable(en4),
        .o_clear(clr4), .o_done(done4), .o_halted(halted4), .o_state(state4),
        .o_cycle_count(count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_mode  = 1;
        m_left  = CLEAR_CYCLES;
        m_count = 0;
    endtask

    // One clock of the command rules, using inputs present at the edge
    task automatic model_step();
        int c;
        c = (cmd_valid && (m_mode == 0 || m_mode == 2 || m_mode == 4)) ? int'(cmd) : 0;
        if (m_en) m_count = m_count + 1;
        m_done = 0;
        case (m_mode)
            0: begin
                if (c == C_CLEAR) model_clear();
                else if (c == C_RUN) m_mode = 2;
                else if (c == C_STEP) begin
                    m_mode = 3;
                    m_left = (step_n == 8'd0) ? 1 : int'(step_n);
                end
            end
            1: begin
                m_left--;
                if (m_left == 0) begin m_mode = 0; m_done = 1; end
            end
            2: begin
                if (halt) begin m_mode = 4; m_done = 1; end
                else if (c == C_CLEAR) model_clear();
                else if (c == C_STOP) m_mode = 0;
            end
            3: begin
                m_left--;
                if (halt) begin m_mode = 4; m_done = 1; end
                else if (m_left == 0) begin m_mode = 0; m_done = 1; end
            end
            4: begin
                if (c == C_CLEAR) model_clear();
            end
            default: ;
        endcase
        m_en     = (m_mode == 2 || m_mode == 3);
        m_clr    = (m_mode == 1);
        m_halted = (m_mode == 4);
    endtask

    // Model advances on each rising edge, or resets asynchronously
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = 0; m_left = 0; m_count = 0;
                m_en = 0; m_clr = 0; m_done = 0; m_halted = 0;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("ready",   ready,  (m_mode == 0 || m_mode == 2 || m_mode == 4) ? 1 : 0);
            chk("enable",  en,     m_en);
            chk("clear",   clr,    m_clr);
            chk("done",    done,   m_done);
            chk("halted",  halted, m_halted);
            chk("state",   state,  m_mode);
            chk("count",   count,  (m_count > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_count);
            chk("state4",  state4, m_mode);
            chk("count4",  count4, (m_count > 15) ? 15 : m_count);
        end
    end

    // Present a command for exactly one rising edge
    task automatic issue(input int c, input int n);
        cmd_valid = 1'b1;
        cmd       = 3'(c);
        step_n    = 8'(n);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        step_n    = 8'd0;
    endtask

    // Count enabled cycles until o_done, bounded
    task automatic wait_done(input string name, input int bound, output int n_en);
        bit seen;
        n_en = 0;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            if (en) n_en++;
            if (done) seen = 1;
            else @(negedge clk);
        end
        chk({name, "_done_seen"}, seen, 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b1; cmd_valid = 1'b0; cmd = 3'd0; step_n = 8'd0; halt = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_ready", ready, 1);
        chk("rst_enable", en, 0);
        chk("rst_count", count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // halt ignored in IDLE, NOP accepted without effect
        halt = 1'b1; @(negedge clk); halt = 1'b0;
        chk("idle_halt_state", state, 0);
        issue(7, 0);
        chk("nop_state", state, 0);

        // CLEAR: two clear cycles then done
        issue(C_CLEAR, 0);
        chk("clr1_clear", clr, 1);
        chk("clr1_ready", ready, 0);
        @(negedge clk);
        chk("clr2_clear", clr, 1);
        @(negedge clk);
        chk("clr_end_clear", clr, 0);
        chk("clr_end_done", done, 1);
        chk("clr_end_state", state, 0);
        chk("clr_end_count", count, 0);

        // STEP 5, then STEP 0 (treated as 1)
        issue(C_STEP, 5);
        chk("step5_ready", ready, 0);
        wait_done("step5", 20, n);
        chk("step5_en_cycles", n, 5);
        chk("step5_count", count, 5);
        chk("step5_state", state, 0);
        issue(C_STEP, 0);
        wait_done("step0", 10, n);
        chk("step0_en_cycles", n, 1);
        chk("step0_count", count, 6);

        // RUN, halt after 10 enabled cycles
        issue(C_CLEAR, 0);
        wait_done("clrA", 10, n);
        issue(C_RUN, 0);
        repeat (9) @(negedge clk);
        halt = 1'b1; @(negedge clk); halt = 1'b0;
        chk("halt_enable", en, 0);
        chk("halt_halted", halted, 1);
        chk("halt_done", done, 1);
        chk("halt_count", count, 10);
        @(negedge clk);
        chk("halt_done_fall", done, 0);
        issue(C_RUN, 0);
        chk("halted_run_ignored", state, 4);
        issue(C_CLEAR, 0);
        wait_done("clrB", 10, n);
        chk("clrB_halted", halted, 0);
        chk("clrB_state", state, 0);

        // STOP and halt together: halt wins
        issue(C_RUN, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd = 3'(C_STOP); halt = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd = 3'd0; halt = 1'b0;
        chk("stop_halt_state", state, 4);
        issue(C_CLEAR, 0);
        wait_done("clrC", 10, n);

        // RUN then STOP alone
        issue(C_RUN, 0);
        repeat (3) @(negedge clk);
        issue(C_STOP, 0);
        chk("stop_enable", en, 0);
        chk("stop_state", state, 0);
        chk("stop_count", count, 4);

        // CLEAR from RUN zeroes the counter at once
        issue(C_RUN, 0);
        @(negedge clk);
        issue(C_CLEAR, 0);
        chk("run_clr_clear", clr, 1);
        chk("run_clr_count", count, 0);
        wait_done("clrD", 10, n);

        // STEP 3 with halt on cycle 2
        issue(C_STEP, 3);
        @(negedge clk);
        halt = 1'b1; @(negedge clk); halt = 1'b0;
        chk("step_halt_state", state, 4);
        chk("step_halt_done", done, 1);
        chk("step_halt_count", count, 2);
        @(negedge clk);
        chk("step_halt_done_fall", done, 0);
        issue(C_CLEAR, 0);
        wait_done("clrE", 10, n);

        // Halt on last STEP cycle
        issue(C_STEP, 2);
        @(negedge clk);
        halt = 1'b1; @(negedge clk); halt = 1'b0;
        chk("last_step_halt_state", state, 4);
        chk("last_step_halt_count", count, 2);
        @(negedge clk);
        chk("last_step_done_fall", done, 0);

        // Halt ignored during CLEAR
        issue(C_CLEAR, 0);
        halt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        halt = 1'b0;
        chk("clr_halt_state", state, 0);
        chk("clr_halt_halted", halted, 0);

        // Saturation of the 4-bit counter
        issue(C_RUN, 0);
        repeat (20) @(negedge clk);
        chk("sat_count32", count, 20);
        chk("sat_count4", count4, 15);

        // Asynchronous reset mid-RUN
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_ready", ready, 1);
        chk("arst_enable", en, 0);
        chk("arst_clear", clr, 0);
        chk("arst_done", done, 0);
        chk("arst_halted", halted, 0);
        chk("arst_count", count, 0);
        chk("arst_count4", count4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
